// File: rtl/kf_gain2_seq.sv
// kf_gain2_seq: forms K = M * inv(S) for 2x2 signed fixed-point matrices.
// Hands S to an external serial inverter over a start/done handshake,
// captures the returned inverse into R, then produces one K element per
// cycle using two shared multipliers. A missing inv_done raises a sticky err.
module kf_gain2_seq #(
  parameter int N       = 20,
  parameter int FRAC    = 10,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic signed [N-1:0] s00,
  input  logic signed [N-1:0] s01,
  input  logic signed [N-1:0] s10,
  input  logic signed [N-1:0] s11,
  input  logic signed [N-1:0] m00,
  input  logic signed [N-1:0] m01,
  input  logic signed [N-1:0] m10,
  input  logic signed [N-1:0] m11,
  output logic                inv_start,
  output logic signed [N-1:0] inv_a,
  output logic signed [N-1:0] inv_b,
  output logic signed [N-1:0] inv_c,
  output logic signed [N-1:0] inv_d,
  input  logic                inv_done,
  input  logic signed [N-1:0] inv_ia,
  input  logic signed [N-1:0] inv_ib,
  input  logic signed [N-1:0] inv_ic,
  input  logic signed [N-1:0] inv_id,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic signed [N-1:0] k00,
  output logic signed [N-1:0] k01,
  output logic signed [N-1:0] k10,
  output logic signed [N-1:0] k11
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    MUL   = 2'd3
  } state_t;

  state_t state_r, state_nx_s;

  logic [1:0]          j_r;
  logic [CW-1:0]       cnt_r;
  logic                timeout_s;
  logic signed [N-1:0] s00_r, s01_r, s10_r, s11_r;
  logic signed [N-1:0] m00_r, m01_r, m10_r, m11_r;
  logic signed [N-1:0] r00_r, r01_r, r10_r, r11_r;

  logic signed [N-1:0]   a0_s, a1_s, b0_s, b1_s;
  logic signed [2*N-1:0] a0x_s, a1x_s, b0x_s, b1x_s;
  logic signed [2*N-1:0] p0_s, p1_s, sh0_s, sh1_s;
  logic        [N-1:0]   kval_s;

  // The inverter sees only the latched S, so its operands hold for the whole request.
  assign inv_a = s00_r;
  assign inv_b = s01_r;
  assign inv_c = s10_r;
  assign inv_d = s11_r;

  assign timeout_s = (cnt_r == CW'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; inv_done beats a timeout landing on the same edge.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE:    if (start) state_nx_s = ISSUE; else state_nx_s = IDLE;
      ISSUE:   state_nx_s = WAIT;
      WAIT: begin
        if (inv_done)       state_nx_s = MUL;
        else if (timeout_s) state_nx_s = IDLE;
        else                state_nx_s = WAIT;
      end
      MUL:     if (j_r == 2'd3) state_nx_s = IDLE; else state_nx_s = MUL;
      default: state_nx_s = IDLE;
    endcase
  end

  // Operand select: j[1] picks the M row, j[0] picks the R column.
  always_comb begin
    a0_s   = j_r[1] ? m10_r : m00_r;
    a1_s   = j_r[1] ? m11_r : m01_r;
    b0_s   = j_r[0] ? r01_r : r00_r;
    b1_s   = j_r[0] ? r11_r : r10_r;
    a0x_s  = {{N{a0_s[N-1]}}, a0_s};
    a1x_s  = {{N{a1_s[N-1]}}, a1_s};
    b0x_s  = {{N{b0_s[N-1]}}, b0_s};
    b1x_s  = {{N{b1_s[N-1]}}, b1_s};
    p0_s   = a0x_s * b0x_s;
    p1_s   = a1x_s * b1x_s;
    sh0_s  = p0_s >>> FRAC;
    sh1_s  = p1_s >>> FRAC;
    kval_s = sh0_s[N-1:0] + sh1_s[N-1:0];
  end

  // Operand/result registers, handshake outputs and timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s00_r <= {N{1'b0}}; s01_r <= {N{1'b0}}; s10_r <= {N{1'b0}}; s11_r <= {N{1'b0}};
      m00_r <= {N{1'b0}}; m01_r <= {N{1'b0}}; m10_r <= {N{1'b0}}; m11_r <= {N{1'b0}};
      r00_r <= {N{1'b0}}; r01_r <= {N{1'b0}}; r10_r <= {N{1'b0}}; r11_r <= {N{1'b0}};
      k00   <= {N{1'b0}}; k01   <= {N{1'b0}}; k10   <= {N{1'b0}}; k11   <= {N{1'b0}};
      j_r       <= 2'd0;
      cnt_r     <= {CW{1'b0}};
      inv_start <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done      <= 1'b0;
      inv_start <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            s00_r <= s00; s01_r <= s01; s10_r <= s10; s11_r <= s11;
            m00_r <= m00; m01_r <= m01; m10_r <= m10; m11_r <= m11;
            err       <= 1'b0;
            busy      <= 1'b1;
            inv_start <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        ISSUE: begin
          cnt_r <= {CW{1'b0}};
        end
        WAIT: begin
          if (inv_done) begin
            r00_r <= inv_ia; r01_r <= inv_ib; r10_r <= inv_ic; r11_r <= inv_id;
            j_r   <= 2'd0;
          end else if (timeout_s) begin
            err  <= 1'b1;
            done <= 1'b1;
            busy <= 1'b0;
          end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        MUL: begin
          case (j_r)
            2'd0:    k00 <= kval_s;
            2'd1:    k01 <= kval_s;
            2'd2:    k10 <= kval_s;
            2'd3:    k11 <= kval_s;
            default: k00 <= kval_s;
          endcase
          j_r <= j_r + 2'd1;
          if (j_r == 2'd3) begin
            done <= 1'b1;
            busy <= 1'b0;
          end else begin
            busy <= 1'b1;
          end
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kf_gain2_seq.sv
// Directed bench for kf_gain2_seq; the bench itself plays the inverter.
module tb_kf_gain2_seq;
  localparam int N       = 20;
  localparam int FRAC    = 10;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic signed [N-1:0] s00 = '0, s01 = '0, s10 = '0, s11 = '0;
  logic signed [N-1:0] m00 = '0, m01 = '0, m10 = '0, m11 = '0;
  logic inv_start;
  logic signed [N-1:0] inv_a, inv_b, inv_c, inv_d;
  logic inv_done = 1'b0;
  logic signed [N-1:0] inv_ia = '0, inv_ib = '0, inv_ic = '0, inv_id = '0;
  logic busy, done, err;
  logic signed [N-1:0] k00, k01, k10, k11;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int istart_cnt = 0;
  logic [N-1:0] e_a, e_b, e_c, e_d;

  kf_gain2_seq #(.N(N), .FRAC(FRAC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .s00(s00), .s01(s01), .s10(s10), .s11(s11),
    .m00(m00), .m01(m01), .m10(m10), .m11(m11),
    .inv_start(inv_start), .inv_a(inv_a), .inv_b(inv_b), .inv_c(inv_c), .inv_d(inv_d),
    .inv_done(inv_done), .inv_ia(inv_ia), .inv_ib(inv_ib), .inv_ic(inv_ic), .inv_id(inv_id),
    .busy(busy), .done(done), .err(err),
    .k00(k00), .k01(k01), .k10(k10), .k11(k11)
  );

  always #5 clk = ~clk;

  // Count high cycles of the two pulse outputs.
  always @(posedge clk) begin
    if (rst_n && done) done_cnt++;
    if (rst_n && inv_start) istart_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_k(input string tag, input logic [N-1:0] e00, input logic [N-1:0] e01,
                       input logic [N-1:0] e10, input logic [N-1:0] e11);
    chk({tag, "_k00"}, k00, e00);
    chk({tag, "_k01"}, k01, e01);
    chk({tag, "_k10"}, k10, e10);
    chk({tag, "_k11"}, k11, e11);
  endtask

  task automatic load(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] c,
                      input logic [N-1:0] d, input logic [N-1:0] p, input logic [N-1:0] q,
                      input logic [N-1:0] r, input logic [N-1:0] t);
    s00 = a; s01 = b; s10 = c; s11 = d;
    m00 = p; m01 = q; m10 = r; m11 = t;
  endtask

  // One transaction with a 4-cycle inverter: start at E0, inv_done at E5, done after E9.
  task automatic run_op(input string tag,
                        input logic [N-1:0] r00, input logic [N-1:0] r01,
                        input logic [N-1:0] r10, input logic [N-1:0] r11,
                        input logic [N-1:0] e00, input logic [N-1:0] e01,
                        input logic [N-1:0] e10, input logic [N-1:0] e11,
                        input bit spam);
    e_a = s00; e_b = s01; e_c = s10; e_d = s11;
    start = 1'b1;
    tick(); // E0
    chk({tag, "_istart_hi"}, N'(inv_start), N'(1));
    chk({tag, "_busy_E0"}, N'(busy), N'(1));
    chk({tag, "_err_clr"}, N'(err), N'(0));
    start = spam;
    if (spam) load(20'h12345, 20'h54321, 20'h0F0F0, 20'hABCDE,
                   20'h11111, 20'h22222, 20'h33333, 20'h44444);
    tick(); // E1
    chk({tag, "_istart_lo"}, N'(inv_start), N'(0));
    for (int i = 0; i < 3; i++) begin
      tick(); // E2..E4
      chk({tag, "_istart_wait"}, N'(inv_start), N'(0));
      chk({tag, "_inv_a"}, inv_a, e_a);
      chk({tag, "_inv_b"}, inv_b, e_b);
      chk({tag, "_inv_c"}, inv_c, e_c);
      chk({tag, "_inv_d"}, inv_d, e_d);
    end
    inv_done = 1'b1;
    inv_ia = r00; inv_ib = r01; inv_ic = r10; inv_id = r11;
    tick(); // E5
    inv_done = 1'b0;
    inv_ia = 20'h7777; inv_ib = 20'h7777; inv_ic = 20'h7777; inv_id = 20'h7777;
    for (int i = 0; i < 3; i++) begin
      tick(); // E6..E8
      chk({tag, "_done_early"}, N'(done), N'(0));
      chk({tag, "_busy_mul"}, N'(busy), N'(1));
    end
    tick(); // E9
    start = 1'b0;
    chk({tag, "_done"}, N'(done), N'(1));
    chk({tag, "_busy_end"}, N'(busy), N'(0));
    chk({tag, "_err_end"}, N'(err), N'(0));
    chk_k(tag, e00, e01, e10, e11);
    tick();
    chk({tag, "_done_1cyc"}, N'(done), N'(0));
    chk({tag, "_istart_none"}, N'(inv_start), N'(0));
  endtask

  initial begin
    // Reset values.
    #2;
    chk("rst_busy", N'(busy), N'(0));
    chk("rst_done", N'(done), N'(0));
    chk("rst_err", N'(err), N'(0));
    chk("rst_istart", N'(inv_start), N'(0));
    chk("rst_inv_a", inv_a, N'(0));
    chk_k("rst", N'(0), N'(0), N'(0), N'(0));
    tick();
    rst_n = 1'b1;
    tick();

    // Identity inverse: K = M.
    load(N'(1024), N'(0), N'(0), N'(1024), N'(1024), N'(2048), N'(-512), N'(3072));
    run_op("ident", N'(1024), N'(0), N'(0), N'(1024),
           N'(1024), N'(2048), N'(-512), N'(3072), 1'b0);

    // Diagonal.
    load(N'(2048), N'(0), N'(0), N'(4096), N'(1024), N'(1024), N'(1024), N'(1024));
    run_op("diag", N'(512), N'(0), N'(0), N'(256),
           N'(512), N'(256), N'(512), N'(256), 1'b0);

    // Floor toward -inf: -3*512/1024 = -1.5 -> -2; 3*512/1024 = 1.5 -> 1.
    load(N'(1), N'(2), N'(3), N'(4), N'(-3), N'(0), N'(0), N'(0));
    run_op("floor_neg", N'(512), N'(0), N'(0), N'(0),
           N'(-2), N'(0), N'(0), N'(0), 1'b0);
    load(N'(1), N'(2), N'(3), N'(4), N'(3), N'(0), N'(0), N'(0));
    run_op("floor_pos", N'(512), N'(0), N'(0), N'(0),
           N'(1), N'(0), N'(0), N'(0), 1'b0);

    // Wrap: each term 2^19 wraps to 20'h80000; their sum wraps to 0.
    load(N'(5), N'(6), N'(7), N'(8), N'(262144), N'(262144), N'(0), N'(0));
    run_op("wrap", N'(2048), N'(1024), N'(2048), N'(0),
           N'(0), N'(262144), N'(0), N'(0), 1'b0);

    // Timeout: no inv_done; err/done after E17, K unchanged.
    load(N'(9), N'(9), N'(9), N'(9), N'(1), N'(1), N'(1), N'(1));
    start = 1'b1;
    tick(); // E0
    start = 1'b0;
    tick(); // E1
    for (int i = 2; i <= TIMEOUT; i++) begin
      tick();
      chk("to_done_early", N'(done), N'(0));
      chk("to_err_early", N'(err), N'(0));
    end
    tick(); // E17
    chk("to_done", N'(done), N'(1));
    chk("to_err", N'(err), N'(1));
    chk("to_busy", N'(busy), N'(0));
    chk_k("to", N'(0), N'(262144), N'(0), N'(0));
    tick();
    chk("to_done_1cyc", N'(done), N'(0));
    chk("to_err_sticky", N'(err), N'(1));

    // Recovery after timeout clears err.
    load(N'(1024), N'(0), N'(0), N'(1024), N'(1024), N'(2048), N'(-512), N'(3072));
    run_op("recover", N'(1024), N'(0), N'(0), N'(1024),
           N'(1024), N'(2048), N'(-512), N'(3072), 1'b0);

    // start held high throughout WAIT/MUL with junk operands: ignored.
    load(N'(77), N'(-88), N'(99), N'(-11), N'(100), N'(-200), N'(300), N'(-400));
    run_op("spam", N'(1024), N'(0), N'(0), N'(1024),
           N'(100), N'(-200), N'(300), N'(-400), 1'b1);

    // Spurious inv_done in IDLE.
    inv_done = 1'b1;
    inv_ia = N'(5); inv_ib = N'(5); inv_ic = N'(5); inv_id = N'(5);
    tick();
    inv_done = 1'b0;
    chk("idle_done_busy", N'(busy), N'(0));
    chk("idle_done_istart", N'(inv_start), N'(0));
    tick();
    chk("idle_done_done", N'(done), N'(0));
    chk_k("idle_done", N'(100), N'(-200), N'(300), N'(-400));

    // Reset during WAIT, late inv_done ignored.
    load(N'(1024), N'(0), N'(0), N'(1024), N'(1024), N'(1024), N'(1024), N'(1024));
    start = 1'b1;
    tick(); // E0
    start = 1'b0;
    tick(); // E1
    tick(); // E2
    #3;
    rst_n = 1'b0;
    #1;
    chk("rw_busy", N'(busy), N'(0));
    chk("rw_inv_a", inv_a, N'(0));
    chk("rw_istart", N'(inv_start), N'(0));
    chk_k("rw", N'(0), N'(0), N'(0), N'(0));
    tick(); // E3
    rst_n = 1'b1;
    tick(); // E4
    inv_done = 1'b1;
    inv_ia = N'(1024); inv_ib = N'(0); inv_ic = N'(0); inv_id = N'(1024);
    tick(); // E5
    inv_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rw_no_done", N'(done), N'(0));
      chk("rw_idle_busy", N'(busy), N'(0));
    end
    chk_k("rw_after", N'(0), N'(0), N'(0), N'(0));
    chk("rw_err", N'(err), N'(0));

    // Pulse totals: 8 done pulses, 9 inverter requests.
    chk("done_total", N'(done_cnt), N'(8));
    chk("istart_total", N'(istart_cnt), N'(9));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time guard.
  initial begin
    #200000;
    $display("FAIL timeout_guard observed=running expected=finished");
    $fatal(1, "bench time limit");
  end
endmodule

// File: doc/kf_gain2_seq.md
# kf_gain2_seq

Sequencer that computes the 2x2 gain product K = M · inv(S) in signed fixed point. Acts as the initiator on the start/done handshake of the team's serial 2x2 inverter: presents S, pulses the inverter start, waits for its done, captures the inverse, then forms K serially with two shared multipliers. Sits in the Kalman update path between innovation-covariance formation and the state/covariance update.

## Interface
- N, 20, word width of all matrix elements (signed)
- FRAC, 10, fractional bits (Q(N-FRAC-1).FRAC)
- TIMEOUT, 16, max WAIT cycles for inv_done before error (>=2)
- clk  in  1  clock, rising edge
- rst_n  in  1  reset rst_n, asynchronous, active-low; clock clk
- start  in  1  request; sampled only in IDLE
- s00,s01,s10,s11  in  N each  matrix S, row-major; sampled on accepted start
- m00,m01,m10,m11  in  N each  matrix M, row-major; sampled on accepted start
- inv_start  out  1  one-cycle pulse to inverter
- inv_a,inv_b,inv_c,inv_d  out  N each  S00,S01,S10,S11 to inverter, from internal S registers
- inv_done  in  1  inverter result valid (one-cycle pulse)
- inv_ia,inv_ib,inv_ic,inv_id  in  N each  inverse elements, row-major; valid with inv_done
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle completion pulse (success or error)
- err  out  1  timeout flag, sticky
- k00,k01,k10,k11  out  N each  result K, registered

## Operation
- States: IDLE, ISSUE, WAIT, MUL (2-bit index j), back to IDLE.
- IDLE: start=1 -> latch S, M; clear err; busy<=1; inv_start<=1; -> ISSUE. start=0 or inv_done in IDLE ignored.
- ISSUE: inv_start<=0; clear timeout counter; -> WAIT.
- WAIT: inv_done=1 -> latch inv_ia..id into R registers, j<=0, -> MUL. Else counter increments; when counter reaches TIMEOUT-1 with no inv_done: err<=1, done<=1, busy<=0, -> IDLE; K registers unchanged.
- MUL, j=0..3: one K element per cycle, order k00,k01,k10,k11:
  - k00 = M00·R00 + M01·R10; k01 = M00·R01 + M01·R11
  - k10 = M10·R00 + M11·R10; k11 = M10·R01 + M11·R11
  - j=3: also done<=1, busy<=0, -> IDLE.
- Arithmetic: each product full 2N bits, arithmetic shift right FRAC (floor toward -inf), keep low N bits (wrap). Sum of two N-bit terms wraps to N bits. No saturation, no rounding.
- inv_a..inv_d stable from inv_start cycle through inv_done (driven only from S registers, which change only on accepted start).
- start while busy: ignored, no effect on latched operands.
- inv_done outside WAIT: ignored.

## Timing
- Reset: state IDLE; busy, done, err, inv_start = 0; inv_a..inv_d, k00..k11, internal S/M/R registers, counter = 0.
- Edge E0 accepts start; inv_start high E0->E1; WAIT from E1.
- inv_done sampled at edge Ed (d>=2) -> k00..k11 written at Ed+1..Ed+4; done high for the single cycle after Ed+4; busy low same cycle.
- With a 4-cycle inverter sampling inv_start at E1 (inv_done sampled E5): done visible after E9.
- Timeout: no inv_done at E2..E(TIMEOUT+1) -> err and done visible after E(TIMEOUT+1); TIMEOUT=16 -> E17.
- inv_done at the same edge the timeout would fire: inv_done wins, no error.
- New start accepted in the cycle done is high (state IDLE): that start clears err.
- Reset asserted mid-operation: immediate return to reset values; inverter's late inv_done after reset ignored (FSM in IDLE).
- err stays high until next accepted start or reset.

## Test plan
- Identity: stub inverter returns R=I (1024,0,0,1024), M=(1024,2048,-512,3072) -> K=M exactly; done after E9 with 4-cycle stub; inv_start exactly one cycle; inv_a..d = S throughout WAIT.
- Diagonal: S=(2048,0,0,4096), stub R=(512,0,0,256), M all 1024 -> K=(512,256,512,256).
- Floor truncation: M00=-3, M01=0, R00=512 -> k00=-2 (not -1); M00=3 -> k00=1.
- Timeout: stub never asserts inv_done, TIMEOUT=16 -> err=1 and done pulse after E17, K unchanged, busy=0; next start with responsive stub clears err and completes.
- Busy/spurious: start pulsed every cycle during WAIT and MUL, and inv_done pulsed in IDLE -> no extra inv_start, operands and results unchanged, single done per accepted start.
- Reset in WAIT: rst_n low 1 cycle at E3 -> all outputs 0; stub's inv_done at E5 ignored; no done.
